alu_arbiter: RTL
================

Name: alu_arbiter

Overview:
Two-requester scheduler that shares the single combinational 16-bit ALU between two clients, e.g. the core execute stage (req0) and an auxiliary address/loop unit (req1). It provides round-robin arbitration, operand capture, issue of one operation per grant to the ALU, and registered result/flag return over valid/ready handshakes. It also keeps an architectural status-flags register, updated by every completed operation, for the branch unit.

Parameters:
DATA_W, 16, operand/result width; must match the ALU.
OP_W, 6, opcode width; encodings come from the shared ALU opcode header.
FLAG_W, 4, flag width; bit order {Z,N,C,O} = bits [3:0].

Ports:
clk  in  1  system clock, rising edge
rst  in  1  synchronous reset, active-high
req0_valid  in  1  requester 0 has an operation
req0_ready  out  1  requester 0 operation accepted this cycle
req0_op  in  OP_W  requester 0 opcode
req0_a  in  DATA_W  requester 0 operand A
req0_b  in  DATA_W  requester 0 operand B/immediate
req1_valid, req1_ready, req1_op, req1_a, req1_b  same as above, requester 1
rsp0_valid  out  1  result ready for requester 0
rsp0_ready  in  1  requester 0 takes the result
rsp1_valid  out  1  result ready for requester 1
rsp1_ready  in  1  requester 1 takes the result
rsp_result  out  DATA_W  shared result bus, valid with rspN_valid
rsp_flags  out  FLAG_W  shared flag bus, valid with rspN_valid
alu_enable  out  1  ALU enable
alu_opcode  out  OP_W  ALU opcode
alu_a  out  DATA_W  ALU operand A
alu_b  out  DATA_W  ALU operand B
alu_result  in  DATA_W  ALU result (combinational)
alu_flags  in  FLAG_W  ALU flags (combinational)
status_flags  out  FLAG_W  flags of last completed operation
busy  out  1  high in any state other than IDLE

Behaviour:
- Clocking: one clock, clk. rst is synchronous and active-high.
- Reset: the FSM goes to IDLE. All outputs are 0, including req*_ready, rsp*_valid, rsp_result, rsp_flags, alu_*, status_flags and busy. last_grant resets to 1, so req0 wins the first contention.
- FSM states: IDLE, EXEC, RESP.
- IDLE:
  - req*_ready is combinational and goes high only for the winner.
  - Only req0 valid: grant 0. Only req1 valid: grant 1.
  - Both valid: grant !last_grant.
  - On grant, at the clock edge: capture op/a/b and the grant id, update last_grant, go to EXEC.
  - No valid request: stay in IDLE.
- EXEC (exactly 1 cycle):
  - alu_enable=1 and alu_opcode/alu_a/alu_b are driven from the captured registers.
  - At the edge, register alu_result into rsp_result and alu_flags into rsp_flags. status_flags takes the same flags value. Go to RESP.
- RESP:
  - rsp{id}_valid=1; the other rsp valid stays 0.
  - rsp_result/rsp_flags are held stable until rsp{id}_ready=1 at a clock edge; then go to IDLE.
  - rsp_ready from the non-granted requester is ignored.
- ALU drive outside EXEC: alu_enable=0; alu_opcode/alu_a/alu_b hold their last captured values (0 after reset).
- Result override: for ops `ALU_CMP, `ALU_TST and `ALU_NOP, rsp_result is forced to 0. The ALU leaves its result stale for these ops. Flags are still taken from alu_flags.
- Latency and throughput: request accepted at edge T, rspN_valid high in cycle T+2. Minimum spacing is 3 cycles per operation, with no overlap.
- Back-pressure: a requester whose valid is held while the other is served keeps waiting. Its operands are sampled only on its own grant.
- Starvation: with both requesters continuously valid, grants strictly alternate 0,1,0,1.
- Reset mid-operation: the in-flight op is discarded, no response is issued, and status_flags is cleared.
- Width rules: results and flags are passed unmodified. The block does no arithmetic on operands.

Optional Feature:
Macro ALU_ARBITER_DIVZERO_EN.
- Defined: when the captured op is `ALU_DIV or `ALU_MOD with b==0:
  - EXEC keeps alu_enable=0.
  - rsp_result=16'hFFFF and rsp_flags=4'b0011 (C and O set) are forced; status_flags is updated the same way.
  - Latency is unchanged (T+2).
- Not defined: the op is issued to the ALU unmodified, and the result/flags are whatever the ALU returns.

Test Plan:
- Reset, then req0 ADD a=3, b=4 at T -> req0_ready pulses at T; alu_enable=1 in T+1; rsp0_valid at T+2 with result 7, flags 0; busy low after rsp0_ready.
- req0 and req1 both continuously valid, 4 ops each (SUB 5-5, INC 0xFFFF, ...) -> grant order 0,1,0,1,...; SUB response result 0 with flags Z=1; INC 0xFFFF response result 0 with Z=1 and C=1.
- req1 CMP a=2, b=5 -> rsp_result=0, rsp_flags N=1, C=1; status_flags equals rsp_flags.
- rsp0_ready held low 5 cycles during RESP -> rsp0_valid and result stay stable; req1_valid pending is not granted until the handshake completes.
- Assert rst in EXEC -> next cycle all outputs 0, no rsp valid; a following req1 MUL 300x300 -> result 0x5F90, C=1.
- With ALU_ARBITER_DIVZERO_EN, DIV a=9, b=0 -> alu_enable stays 0; result 0xFFFF, flags 4'b0011. Without the macro -> ALU output is returned.

Source files
------------

// File: rtl/alu_arbiter_if.sv
// alu_arbiter_if: request, response and ALU-side signals of the two-client ALU arbiter.
// The slave modport is the arbiter; the master modport is the requesters plus the ALU.
interface alu_arbiter_if #(
  parameter int DATA_W = 16,
  parameter int OP_W   = 6,
  parameter int FLAG_W = 4
);
  logic              req0_valid;
  logic              req0_ready;
  logic [OP_W-1:0]   req0_op;
  logic [DATA_W-1:0] req0_a;
  logic [DATA_W-1:0] req0_b;
  logic              req1_valid;
  logic              req1_ready;
  logic [OP_W-1:0]   req1_op;
  logic [DATA_W-1:0] req1_a;
  logic [DATA_W-1:0] req1_b;
  logic              rsp0_valid;
  logic              rsp0_ready;
  logic              rsp1_valid;
  logic              rsp1_ready;
  logic [DATA_W-1:0] rsp_result;
  logic [FLAG_W-1:0] rsp_flags;
  logic              alu_enable;
  logic [OP_W-1:0]   alu_opcode;
  logic [DATA_W-1:0] alu_a;
  logic [DATA_W-1:0] alu_b;
  logic [DATA_W-1:0] alu_result;
  logic [FLAG_W-1:0] alu_flags;
  logic [FLAG_W-1:0] status_flags;
  logic              busy;

  modport slave (
    input  req0_valid, req0_op, req0_a, req0_b,
    input  req1_valid, req1_op, req1_a, req1_b,
    input  rsp0_ready, rsp1_ready, alu_result, alu_flags,
    output req0_ready, req1_ready, rsp0_valid, rsp1_valid,
    output rsp_result, rsp_flags, alu_enable, alu_opcode, alu_a, alu_b,
    output status_flags, busy
  );

  modport master (
    output req0_valid, req0_op, req0_a, req0_b,
    output req1_valid, req1_op, req1_a, req1_b,
    output rsp0_ready, rsp1_ready, alu_result, alu_flags,
    input  req0_ready, req1_ready, rsp0_valid, rsp1_valid,
    input  rsp_result, rsp_flags, alu_enable, alu_opcode, alu_a, alu_b,
    input  status_flags, busy
  );
endinterface

// File: rtl/alu_arbiter.sv
// alu_arbiter: round-robin scheduler sharing one combinational ALU between two requesters.
// Optional feature macro ALU_ARBITER_DIVZERO_EN traps DIV/MOD by zero without issuing to the ALU.
//
// state | meaning
// IDLE  | arbitrate; ready goes to the winner only
// EXEC  | captured op drives the ALU for one cycle
// RESP  | registered result held until the granted requester takes it
`ifndef ALU_ADD
`define ALU_ADD 6'h00
`endif
`ifndef ALU_SUB
`define ALU_SUB 6'h01
`endif
`ifndef ALU_INC
`define ALU_INC 6'h02
`endif
`ifndef ALU_MUL
`define ALU_MUL 6'h03
`endif
`ifndef ALU_DIV
`define ALU_DIV 6'h04
`endif
`ifndef ALU_MOD
`define ALU_MOD 6'h05
`endif
`ifndef ALU_CMP
`define ALU_CMP 6'h06
`endif
`ifndef ALU_TST
`define ALU_TST 6'h07
`endif
`ifndef ALU_NOP
`define ALU_NOP 6'h08
`endif
`ifndef ALU_AND
`define ALU_AND 6'h09
`endif
`ifndef ALU_XOR
`define ALU_XOR 6'h0A
`endif

module alu_arbiter #(
  parameter int DATA_W = 16,
  parameter int OP_W   = 6,
  parameter int FLAG_W = 4
) (
  input logic          clk,
  input logic          rst,
  alu_arbiter_if.slave bus
);
  typedef enum logic [1:0] {S_IDLE, S_EXEC, S_RESP} state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic              r_last_grant;
  logic              r_gnt_id;
  logic [OP_W-1:0]   r_op;
  logic [DATA_W-1:0] r_a;
  logic [DATA_W-1:0] r_b;
  logic [DATA_W-1:0] r_result;
  logic [FLAG_W-1:0] r_flags;
  logic [FLAG_W-1:0] r_status;

  logic w_req_any;
  logic w_grant_id;
  logic w_accept;
  logic w_no_result;
  logic w_divzero;
  logic w_req0_ready;
  logic w_req1_ready;
  logic w_rsp0_valid;
  logic w_rsp1_valid;
  logic w_alu_enable;

  assign w_req_any  = bus.req0_valid | bus.req1_valid;
  // On contention the requester not served last wins; otherwise whoever is asking.
  assign w_grant_id = (bus.req0_valid & bus.req1_valid) ? ~r_last_grant : bus.req1_valid;
  assign w_accept   = w_req0_ready | w_req1_ready;

  // The ALU leaves its result stale for flag-only ops.
  assign w_no_result = (r_op == `ALU_CMP) || (r_op == `ALU_TST) || (r_op == `ALU_NOP);

`ifdef ALU_ARBITER_DIVZERO_EN
  assign w_divzero = ((r_op == `ALU_DIV) || (r_op == `ALU_MOD)) && (r_b == '0);
`else
  assign w_divzero = 1'b0;
`endif

  always_comb begin
    w_state_nxt  = r_state;
    w_req0_ready = 1'b0;
    w_req1_ready = 1'b0;
    w_rsp0_valid = 1'b0;
    w_rsp1_valid = 1'b0;
    w_alu_enable = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_req_any && !rst) begin
          w_req0_ready = ~w_grant_id;
          w_req1_ready = w_grant_id;
          w_state_nxt  = S_EXEC;
        end
      end
      S_EXEC: begin
        w_alu_enable = ~w_divzero;
        w_state_nxt  = S_RESP;
      end
      S_RESP: begin
        w_rsp0_valid = ~r_gnt_id;
        w_rsp1_valid = r_gnt_id;
        if (r_gnt_id ? bus.rsp1_ready : bus.rsp0_ready) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_last_grant <= 1'b1;
      r_gnt_id     <= 1'b0;
      r_op         <= '0;
      r_a          <= '0;
      r_b          <= '0;
      r_result     <= '0;
      r_flags      <= '0;
      r_status     <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_accept) begin
        r_gnt_id     <= w_grant_id;
        r_last_grant <= w_grant_id;
        r_op         <= w_grant_id ? bus.req1_op : bus.req0_op;
        r_a          <= w_grant_id ? bus.req1_a  : bus.req0_a;
        r_b          <= w_grant_id ? bus.req1_b  : bus.req0_b;
      end
      if (r_state == S_EXEC) begin
        if (w_divzero) begin
          r_result <= '1;
          r_flags  <= FLAG_W'(4'b0011);
          r_status <= FLAG_W'(4'b0011);
        end else begin
          r_result <= w_no_result ? '0 : bus.alu_result;
          r_flags  <= bus.alu_flags;
          r_status <= bus.alu_flags;
        end
      end
    end
  end

  assign bus.req0_ready   = w_req0_ready;
  assign bus.req1_ready   = w_req1_ready;
  assign bus.rsp0_valid   = w_rsp0_valid;
  assign bus.rsp1_valid   = w_rsp1_valid;
  assign bus.rsp_result   = r_result;
  assign bus.rsp_flags    = r_flags;
  assign bus.alu_enable   = w_alu_enable;
  assign bus.alu_opcode   = r_op;
  assign bus.alu_a        = r_a;
  assign bus.alu_b        = r_b;
  assign bus.status_flags = r_status;
  assign bus.busy         = (r_state != S_IDLE);
endmodule
